// File: rtl/pulse_correlator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pulse_correlator: per-channel and pairwise-coincidence pulse counters with a
// periodic snapshot read out over a valid/ready stream.
// Optional input synchroniser: define PULSE_CORR_INPUT_SYNC_EN.
// Revision: 1.0
// ============================================================================
module pulse_correlator #(
  parameter int NUM_INPUTS   = 12,
  parameter int RESOLUTION   = 16,
  parameter int INTEG_CYCLES = 400000,
  parameter int ACTIVE_LOW   = 1,
  localparam int NUM_CORRELATORS = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
  localparam int NUM_WORDS       = NUM_INPUTS + NUM_CORRELATORS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_INPUTS-1:0]        pulse_in,
  input  logic                         enable,
  output logic [NUM_INPUTS-1:0]        pulse_out,
  output logic                         integration_clk_pulse,
  output logic [RESOLUTION-1:0]        out_data,
  output logic [$clog2(NUM_WORDS)-1:0] out_index,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         overflow,
  output logic                         frame_dropped
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int TMR_W = $clog2(INTEG_CYCLES);
  localparam logic [RESOLUTION-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMR_W-1:0]      TMR_END  = TMR_W'(INTEG_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  logic [NUM_INPUTS-1:0] p_cond;
  logic [NUM_INPUTS-1:0] p_edge;
  logic [NUM_INPUTS-1:0] p_prev_q, p_prev_d;
  logic [NUM_INPUTS-1:0] pulse_out_q, pulse_out_d;
  logic [NUM_WORDS-1:0]  hit;

  logic [RESOLUTION-1:0] cnt_q    [NUM_WORDS];
  logic [RESOLUTION-1:0] cnt_d    [NUM_WORDS];
  logic [RESOLUTION-1:0] shadow_q [NUM_WORDS];
  logic [RESOLUTION-1:0] shadow_d [NUM_WORDS];
  logic                  ovf_q, ovf_d;
  logic                  shadow_ovf_q, shadow_ovf_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  terminal;
  logic                  icp_q, icp_d;
  logic                  drop_q, drop_d;
  state_t                state_q, state_d;
  logic [IDX_W-1:0]      index_q, index_d;

  assign p_cond = (ACTIVE_LOW != 0) ? ~pulse_in : pulse_in;

`ifdef PULSE_CORR_INPUT_SYNC_EN
  logic [NUM_INPUTS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= p_cond;
      sync2_q <= sync1_q;
    end
  end

  assign p_edge = sync2_q;
`else
  assign p_edge = p_cond;
`endif

  assign p_prev_d    = p_edge;
  assign pulse_out_d = p_edge & ~p_prev_q;

  // Word map: singles 0..N-1, then pairs (0,1),(0,2)..(0,N-1),(1,2)..
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_single
    assign hit[gi] = pulse_out_q[gi];
  end

  for (genvar gi = 0; gi < NUM_INPUTS - 1; gi++) begin : g_row
    for (genvar gj = gi + 1; gj < NUM_INPUTS; gj++) begin : g_pair
      localparam int K = NUM_INPUTS + gi * NUM_INPUTS - gi * (gi + 1) / 2 + (gj - gi - 1);
      assign hit[K] = pulse_out_q[gi] & pulse_out_q[gj];
    end
  end

  assign terminal = enable && (timer_q == TMR_END);

  always_comb begin
    timer_d = timer_q;
    ovf_d   = ovf_q;
    if (enable) begin
      timer_d = terminal ? '0 : timer_q + TMR_W'(1);
    end
    for (int w = 0; w < NUM_WORDS; w++) begin
      cnt_d[w] = cnt_q[w];
      // A strobe in the terminal cycle opens the new period with a count of 1.
      if (terminal) begin
        cnt_d[w] = hit[w] ? RESOLUTION'(1) : '0;
      end else if (enable && hit[w]) begin
        if (cnt_q[w] == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[w] = cnt_q[w] + RESOLUTION'(1);
        end
      end
    end
    if (terminal) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    shadow_d     = shadow_q;
    shadow_ovf_d = shadow_ovf_q;
    icp_d        = terminal;
    drop_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (terminal) begin
          shadow_d     = cnt_q;
          shadow_ovf_d = ovf_q;
          state_d      = ST_SEND;
          index_d      = '0;
        end
      end
      ST_SEND: begin
        // Readout still busy: this period's counts are lost, shadow is kept.
        if (terminal) begin
          drop_d = 1'b1;
        end
        if (out_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = ST_IDLE;
            index_d = '0;
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        index_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_prev_q     <= '0;
      pulse_out_q  <= '0;
      cnt_q        <= '{default: '0};
      shadow_q     <= '{default: '0};
      ovf_q        <= 1'b0;
      shadow_ovf_q <= 1'b0;
      timer_q      <= '0;
      icp_q        <= 1'b0;
      drop_q       <= 1'b0;
      state_q      <= ST_IDLE;
      index_q      <= '0;
    end else begin
      p_prev_q     <= p_prev_d;
      pulse_out_q  <= pulse_out_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      ovf_q        <= ovf_d;
      shadow_ovf_q <= shadow_ovf_d;
      timer_q      <= timer_d;
      icp_q        <= icp_d;
      drop_q       <= drop_d;
      state_q      <= state_d;
      index_q      <= index_d;
    end
  end

  assign pulse_out             = pulse_out_q;
  assign integration_clk_pulse = icp_q;
  assign frame_dropped         = drop_q;
  assign out_valid             = (state_q == ST_SEND);
  assign out_index             = index_q;
  assign out_data              = out_valid ? shadow_q[index_q] : '0;
  assign out_last              = out_valid && (index_q == LAST_IDX);
  assign overflow              = out_valid && shadow_ovf_q;

endmodule
`default_nettype wire
